// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the byte FIFO and its read-side controller:
//   default data width, FIFO depth and the drain controller state encoding.
package fifo_pkg;

    localparam int FIFO_DEPTH    = 32;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage : fifo_pkg

// File: rtl/skid_buf.sv
// skid_buf
//   Small circular buffer that absorbs the FIFO read latency and presents
//   its head entry as a valid/ready stream.
//
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   i_wr       in   capture i_wr_data at this edge
//   i_wr_data  in   byte arriving from the FIFO
//   i_rdy      in   downstream ready
//   o_valid    out  buffer holds at least one entry
//   o_data     out  head entry (0 while empty)
//   o_pop      out  head entry accepted at this edge
//   o_cnt      out  occupancy, 0..DEPTH
module skid_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rdy,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_pop,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_pop;

    assign o_valid = (r_cnt != '0);
    assign w_pop   = o_valid && i_rdy;
    assign o_pop   = w_pop;
    assign o_cnt   = r_cnt;
    // Gate with o_valid so the stream data reads 0 out of reset even though
    // the storage itself is never cleared.
    assign o_data  = o_valid ? r_mem[r_rp] : '0;

    // NOTE: the storage array has no reset; occupancy tracking guarantees an
    // entry is never read before it is written, and leaving it unreset keeps
    // it mappable to plain flops/LUT RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff in the design samples pre-edge values regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_wr) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            // Capture and pop on the same edge leave occupancy unchanged.
            case ({i_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : skid_buf

// File: rtl/fifo_drain.sv
// fifo_drain
//   Read-side controller for the 32-entry byte FIFO. Pops the FIFO, absorbs
//   its one-cycle read latency in skid_buf and streams bytes downstream at up
//   to one per clock, with enable/flush control and a transfer counter.
//
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   1 = fetch from FIFO, 0 = stop fetching and flush
//   fifo_rd     out  pop request to the FIFO
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO registered read data (one cycle after fifo_rd)
//   m_valid     out  stream data valid
//   m_ready     in   stream consumer ready
//   m_data      out  stream data
//   busy        out  controller not idle
//   xfer_cnt    out  bytes accepted downstream (wraps)
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             fifo_rd,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int CW = $clog2(SKID_DEPTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_infl;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic [CW-1:0]    w_cnt;
    logic [CW-1:0]    w_occ;
    logic             w_pop;

    skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (r_infl),
        .i_wr_data (fifo_data),
        .i_rdy     (m_ready),
        .o_valid   (m_valid),
        .o_data    (m_data),
        .o_pop     (w_pop),
        .o_cnt     (w_cnt)
    );

    // Reserve a slot for the byte already in flight so a read is only issued
    // when its data is guaranteed room. Deliberately independent of m_ready.
    assign w_occ   = w_cnt + CW'(r_infl);
    assign fifo_rd = (r_state == ST_STREAM) && !fifo_empty
                     && (w_occ < CW'(SKID_DEPTH));

    assign busy     = (r_state != ST_IDLE);
    assign xfer_cnt = r_xfer_cnt;

    // NOTE: next-state defaults to the current state before the case, so no
    // path through this block leaves w_state_nxt unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (!en) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (en) begin
                    w_state_nxt = ST_STREAM;
                end else if ((w_cnt == '0) && !r_infl) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_infl     <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Data for a read sampled now arrives on fifo_data next cycle.
            r_infl  <= fifo_rd;
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

endmodule : fifo_drain

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain
//   Self-checking bench for fifo_drain: a behavioural 32-entry FIFO with
//   one-cycle read latency feeds the DUT; a table of per-cycle vectors checks
//   streaming, and hand-written sequences cover backpressure, reset, flush,
//   the empty boundary and counter wrap (second instance with CNT_W=4).
module tb_fifo_drain;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       exp_rd;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        m_ready;
    logic        fifo_clr;
    logic        fifo_rd;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        busy;
    logic [15:0] xfer_cnt;

    logic        fifo_rd_w;
    logic        m_valid_w;
    logic [7:0]  m_data_w;
    logic        busy_w;
    logic [3:0]  xfer_cnt_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_drain #(.WIDTH(8), .SKID_DEPTH(4), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .xfer_cnt   (xfer_cnt)
    );

    // Narrow-counter instance sees identical stimulus; only its counter is checked.
    fifo_drain #(.WIDTH(8), .SKID_DEPTH(4), .CNT_W(4)) u_dut_w (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_rd    (fifo_rd_w),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid_w),
        .m_ready    (m_ready),
        .m_data     (m_data_w),
        .busy       (busy_w),
        .xfer_cnt   (xfer_cnt_w)
    );

    // ---------------- behavioural FIFO ----------------
    logic [7:0] fmem [32];
    int         ftail = 0;
    int         fhead = 0;

    assign fifo_empty = (fhead == ftail);

    always @(posedge clk) begin
        if (fifo_clr) begin
            fhead <= ftail;
        end else if (fifo_rd && (fhead != ftail)) begin
            fifo_data <= fmem[fhead % 32];
            fhead     <= fhead + 1;
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] got [$];
    int         rd_count = 0;

    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (fifo_rd) rd_count <= rd_count + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[ftail % 32] = base + 8'(i);
            ftail++;
        end
    endtask

    task automatic step(input logic e, input logic r);
        @(negedge clk);
        en      = e;
        m_ready = r;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fifo_clr = 1'b1;
        en       = 1'b0;
        m_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        fifo_clr = 1'b0;
    endtask

    function automatic vec_t mk(input logic e, input logic r, input logic rd,
                                input logic v, input logic [7:0] d, input logic b);
        vec_t t;
        t.en = e; t.rdy = r; t.exp_rd = rd; t.exp_valid = v; t.exp_data = d; t.exp_busy = b;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [20];
        int   base_rd;
        int   base_got;
        bit   drained;

        // Streaming, 0x10..0x1F preloaded, m_ready=1 throughout.
        vecs[0]  = mk(1, 1, 0, 0, 8'h00, 0);   // IDLE: en sampled at next edge
        vecs[1]  = mk(1, 1, 1, 0, 8'h00, 1);   // first read
        vecs[2]  = mk(1, 1, 1, 0, 8'h00, 1);   // first byte in flight
        for (int k = 3; k <= 16; k++) begin
            vecs[k] = mk(1, 1, 1, 1, 8'h10 + 8'(k - 3), 1);
        end
        vecs[17] = mk(1, 1, 0, 1, 8'h1E, 1);   // FIFO empty, last byte in flight
        vecs[18] = mk(1, 1, 0, 1, 8'h1F, 1);   // last byte still delivered
        vecs[19] = mk(1, 1, 0, 0, 8'h00, 1);   // drained, still STREAM

        // ---- reset values ----
        rst      = 1'b1;
        fifo_clr = 1'b1;
        en       = 1'b0;
        m_ready  = 1'b0;
        #6;
        check("rst.fifo_rd",  32'(fifo_rd),  0);
        check("rst.m_valid",  32'(m_valid),  0);
        check("rst.m_data",   32'(m_data),   0);
        check("rst.busy",     32'(busy),     0);
        check("rst.xfer_cnt", 32'(xfer_cnt), 0);
        @(negedge clk);
        rst      = 1'b0;
        fifo_clr = 1'b0;

        // ---- streaming (table) ----
        load(16, 8'h10);
        for (int k = 0; k < 20; k++) begin
            step(vecs[k].en, vecs[k].rdy);
            check($sformatf("stream[%0d].fifo_rd", k), 32'(fifo_rd), 32'(vecs[k].exp_rd));
            check($sformatf("stream[%0d].m_valid", k), 32'(m_valid), 32'(vecs[k].exp_valid));
            check($sformatf("stream[%0d].m_data", k),  32'(m_data),  32'(vecs[k].exp_data));
            check($sformatf("stream[%0d].busy", k),    32'(busy),    32'(vecs[k].exp_busy));
        end
        check("stream.xfer_cnt", 32'(xfer_cnt), 16);
        check("stream.xfer_cnt_w4", 32'(xfer_cnt_w), 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1);
            check("empty.fifo_rd_low", 32'(fifo_rd), 0);
        end

        // ---- backpressure ----
        do_reset();
        base_rd  = rd_count;
        base_got = got.size();
        load(8, 8'h20);
        for (int i = 0; i < 13; i++) begin
            step(1, 0);
            if (i >= 3) begin
                check("bp.m_valid_held", 32'(m_valid), 1);
                check("bp.m_data_held",  32'(m_data),  32'h20);
            end
        end
        check("bp.reads_stalled", 32'(rd_count - base_rd), 4);
        check("bp.fifo_rd_low",   32'(fifo_rd), 0);
        for (int i = 0; i < 20; i++) step(1, 1);
        check("bp.delivered", 32'(got.size() - base_got), 8);
        for (int i = 0; i < 8; i++) begin
            if (base_got + i < got.size())
                check($sformatf("bp.byte[%0d]", i), 32'(got[base_got + i]), 32'h20 + 32'(i));
        end
        check("bp.xfer_cnt", 32'(xfer_cnt), 8);

        // ---- asynchronous reset mid-transfer ----
        load(4, 8'h30);
        for (int i = 0; i < 4; i++) step(1, 0);
        check("arst.pre_valid", 32'(m_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.m_valid",  32'(m_valid),  0);
        check("arst.m_data",   32'(m_data),   0);
        check("arst.fifo_rd",  32'(fifo_rd),  0);
        check("arst.busy",     32'(busy),     0);
        check("arst.xfer_cnt", 32'(xfer_cnt), 0);

        // ---- flush ----
        do_reset();
        base_rd  = rd_count;
        base_got = got.size();
        load(12, 8'h40);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);                              // en=0 sampled at the coming edge
        check("flush.last_rd", 32'(fifo_rd), 1);
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            step(0, 1);
            if (!busy) drained = 1'b1;
        end
        check("flush.busy_fell",  32'(drained), 1);
        check("flush.reads",      32'(rd_count - base_rd), 3);
        check("flush.delivered",  32'(got.size() - base_got), 3);
        for (int i = 0; i < 3; i++) begin
            if (base_got + i < got.size())
                check($sformatf("flush.byte[%0d]", i), 32'(got[base_got + i]), 32'h40 + 32'(i));
        end
        check("flush.fifo_left", 32'(fifo_empty), 0);
        check("flush.m_valid",   32'(m_valid), 0);

        // ---- counter wrap (CNT_W=4) ----
        do_reset();
        base_got = got.size();
        load(18, 8'h50);
        for (int i = 0; i < 30; i++) step(1, 1);
        check("wrap.xfer_cnt_w4", 32'(xfer_cnt_w), 2);
        check("wrap.xfer_cnt",    32'(xfer_cnt),   18);
        check("wrap.delivered",   32'(got.size() - base_got), 18);
        if (base_got + 17 < got.size())
            check("wrap.last_byte", 32'(got[base_got + 17]), 32'h61);
        check("wrap.fifo_rd_empty", 32'(fifo_rd), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_drain

// File: doc/fifo_drain.md
# fifo_drain

Read-side controller for the 32-entry byte FIFO. It pops bytes through the FIFO's `rd`/`empty`/`data_out` port and absorbs the FIFO's one-cycle read latency in a small internal buffer. It presents the bytes downstream as a valid/ready stream at up to one byte per clock. It sits between the FIFO and any stream consumer (serializer, packetizer). It provides enable/flush control and a transfer counter.

## Interface
- `WIDTH`, 8: data width; must match the FIFO data width.
- `SKID_DEPTH`, 4: internal buffer entries; power of two, 2..8.
- `CNT_W`, 16: transfer counter width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  1 = fetch from FIFO; 0 = stop fetching and flush.
- `fifo_rd`  out  1  pop request to FIFO; the FIFO samples it at the rising edge.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO registered read data; valid in the cycle after the edge that sampled `fifo_rd`=1.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  WIDTH  stream data.
- `busy`  out  1  state != IDLE.
- `xfer_cnt`  out  CNT_W  bytes accepted downstream.

## Operation
- Internal state:
  - `cnt`: buffer occupancy, 0..SKID_DEPTH.
  - `infl`: 1 if a read was issued at the previous edge.
  - `wp`/`rp`: buffer pointers, log2(SKID_DEPTH) bits, wrap naturally.
- Read issue: `fifo_rd` = (state==STREAM) && !fifo_empty && (cnt + infl < SKID_DEPTH).
  - Combinational from registered state and `fifo_empty` only.
  - No path from `m_ready`.
  - The rule never overflows the buffer.
- Capture: when `infl`=1, `fifo_data` is written at `wp` on that edge and `wp` increments.
- Pop: when `m_valid && m_ready`, `rp` increments and `xfer_cnt` increments (wraps modulo 2^CNT_W).
- Same-edge capture and pop: `cnt` is unchanged.
- `m_valid` = (cnt != 0). `m_data` = buffer[rp].
- `m_data` and `m_valid` hold stable while `m_valid && !m_ready`.
- States:
  - IDLE: `en`=1 → STREAM.
  - STREAM: issue reads per rule. `en`=0 → FLUSH.
  - FLUSH: no new reads. Deliver the in-flight byte and all buffered bytes. When `cnt`==0 && `infl`==0 → IDLE. `en` returning to 1 in FLUSH → STREAM immediately.
- `fifo_empty` toggling while `infl`=1 does not affect the in-flight capture.

## Timing
- Reset values: state IDLE, `fifo_rd`=0, `m_valid`=0, `m_data`=0, `busy`=0, `xfer_cnt`=0, `cnt`/`infl`/`wp`/`rp`=0. Buffer contents are don't-care.
- Latency from FIFO to stream:
  - `fifo_rd`=1 sampled at edge N.
  - `fifo_data` valid after N.
  - Captured at N+1.
  - `m_valid`=1 after N+1.
- Latency from `en` to first read: `en` rising sampled at edge E puts the block in STREAM after E, so `fifo_rd` can assert in the following cycle.
- With `m_ready` held at 1 and the FIFO non-empty, sustained throughput is 1 byte/clk (`SKID_DEPTH`≥2; cnt + infl ≤ 2 in steady state).
- Reset asserted mid-transfer:
  - Outputs clear asynchronously.
  - An in-flight FIFO byte is dropped.
  - The FIFO is reset separately by the system.

## Structure
- Shared package `fifo_pkg`:
  - default `WIDTH`
  - state enum (IDLE, STREAM, FLUSH)
  - FIFO depth constant (32)
- Natural sub-module: `skid_buf`, holding the buffer array, `wp`/`rp`/`cnt` and the `m_*` outputs. It is instantiated once.
- The top level holds the FSM, read-issue logic, `infl` and `xfer_cnt`.

## Test plan
- **Reset values:** assert `rst` mid-cycle → all outputs 0 immediately; `busy`=0.
- **Streaming:** FIFO preloaded with 0x10..0x1F, `en`=1, `m_ready`=1 → `m_data` 0x10..0x1F on 16 consecutive cycles; first `m_valid` 2 cycles after first `fifo_rd`; `xfer_cnt`=16.
- **Backpressure:** 8 bytes, `m_ready` low for 10 cycles.
  - `fifo_rd` stops after 4 reads.
  - `m_data`=first byte held stable.
  - Release → remaining bytes delivered in order, none lost or duplicated.
- **Flush:** `en`=0 while the FIFO still holds bytes.
  - Exactly the in-flight and buffered bytes are delivered.
  - No `fifo_rd` after `en`=0 is sampled.
  - `busy` falls when drained.
- **Empty boundary:** FIFO goes empty on the cycle of the last read → that byte still delivered; `fifo_rd` stays 0 while `fifo_empty`=1.
- **Counter wrap:** `CNT_W`=4, 18 transfers → `xfer_cnt`=2.
